// File: rtl/mux_display.sv
// mux_display: time-multiplexed driver for six active-low 7-segment digits.
// Scans s_lsd, s_msd, m_lsd, m_msd, h_lsd, h_msd onto one shared segment bus.
// Each slot opens with BLANK_CYCLES of all-off time, then drives one digit.
// The code is latched at DRIVE start and held until the slot ends.
// Optional feature macro: MUX_BLINK_EN adds mux_blink_mask and per-digit blinking
// with a half-period of BLINK_FRAMES frames.
module mux_display #(
    parameter int CLK_HZ       = 50000000,
    parameter int SCAN_HZ      = 1000,
    parameter int BLANK_CYCLES = 64,
    parameter int BLINK_FRAMES = 83
) (
    input  logic       mux_clock,
    input  logic       mux_reset,
    input  logic       mux_enable,
    input  logic [6:0] mux_s_lsd,
    input  logic [6:0] mux_s_msd,
    input  logic [6:0] mux_m_lsd,
    input  logic [6:0] mux_m_msd,
    input  logic [6:0] mux_h_lsd,
    input  logic [6:0] mux_h_msd,
    output logic [6:0] mux_seg,
    output logic [5:0] mux_an,
    output logic [2:0] mux_digit_idx,
    output logic       mux_frame_tick
`ifdef MUX_BLINK_EN
    ,
    input  logic [5:0] mux_blink_mask
`endif
);

    localparam int DIV   = CLK_HZ / SCAN_HZ;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [2:0]       IDX_LAST   = 3'd5;
    localparam logic [6:0]       SEG_OFF    = 7'h7F;
    localparam logic [5:0]       AN_OFF     = 6'h3F;

    // Reject illegal timing parameters at elaboration.
    if (BLANK_CYCLES < 1 || BLANK_CYCLES >= DIV || BLINK_FRAMES < 1) begin : g_bad_params
        $error("mux_display: need 1 <= BLANK_CYCLES < CLK_HZ/SCAN_HZ and BLINK_FRAMES >= 1");
    end

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic [6:0]       cur_code;
    logic [6:0]       seg_next;
    logic [5:0]       an_next;
    logic             slot_end;
    logic             blank_end;
    logic             frame_wrap;
    logic             blink_hold;

    assign slot_end      = (cnt == CNT_LAST);
    assign blank_end     = (cnt == BLANK_LAST);
    assign frame_wrap    = mux_enable && slot_end && (idx == IDX_LAST);
    assign mux_digit_idx = idx;

    // Select the input code for the digit owning the current slot.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        cur_code = mux_s_lsd;
        case (idx)
            3'd1:    cur_code = mux_s_msd;
            3'd2:    cur_code = mux_m_lsd;
            3'd3:    cur_code = mux_m_msd;
            3'd4:    cur_code = mux_h_lsd;
            3'd5:    cur_code = mux_h_msd;
            default: cur_code = mux_s_lsd;
        endcase
    end

`ifdef MUX_BLINK_EN
    localparam int BF_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BF_W-1:0] BF_LAST = BF_W'(BLINK_FRAMES - 1);

    logic            blink_phase;
    logic [BF_W-1:0] blink_cnt;

    // Blink phase toggles after every BLINK_FRAMES frame wraps; disable clears it.
    always_ff @(posedge mux_clock or negedge mux_reset) begin
        if (!mux_reset) begin
            blink_phase <= 1'b0;
            blink_cnt   <= '0;
        end else if (!mux_enable) begin
            blink_phase <= 1'b0;
            blink_cnt   <= '0;
        end else if (frame_wrap) begin
            if (blink_cnt == BF_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    assign blink_hold = blink_phase && mux_blink_mask[idx];
`else
    assign blink_hold = 1'b0;
`endif

    // Slot counter and digit index; disable parks the scan at slot 0, cycle 0.
    always_ff @(posedge mux_clock or negedge mux_reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!mux_reset) begin
            cnt <= '0;
            idx <= '0;
        end else if (!mux_enable) begin
            cnt <= '0;
            idx <= '0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge mux_clock or negedge mux_reset) begin
        if (!mux_reset) begin
            state <= BLANK;
        end else begin
            state <= state_next;
        end
    end

    // Next state and next registered outputs; bus goes dark on the same edge
    // the slot ends, so a new select never meets an old code.
    always_comb begin
        state_next = state;
        seg_next   = mux_seg;
        an_next    = mux_an;
        if (!mux_enable) begin
            state_next = BLANK;
            seg_next   = SEG_OFF;
            an_next    = AN_OFF;
        end else begin
            case (state)
                BLANK: begin
                    if (blank_end) begin
                        state_next = DRIVE;
                        seg_next   = cur_code;
                        an_next    = blink_hold ? AN_OFF : ~(6'b000001 << idx);
                    end
                end
                DRIVE: begin
                    if (slot_end) begin
                        state_next = BLANK;
                        seg_next   = SEG_OFF;
                        an_next    = AN_OFF;
                    end
                end
                default: begin
                    state_next = BLANK;
                    seg_next   = SEG_OFF;
                    an_next    = AN_OFF;
                end
            endcase
        end
    end

    // Registered segment bus, digit selects and frame pulse.
    always_ff @(posedge mux_clock or negedge mux_reset) begin
        if (!mux_reset) begin
            mux_seg        <= SEG_OFF;
            mux_an         <= AN_OFF;
            mux_frame_tick <= 1'b0;
        end else begin
            mux_seg        <= seg_next;
            mux_an         <= an_next;
            mux_frame_tick <= frame_wrap;
        end
    end

endmodule

// File: tb/tb_mux_display.sv
// tb_mux_display: table-driven scan checks with a per-cycle expectation queue.
// Runs with DIV=10, BLANK_CYCLES=2, so a frame is 60 cycles.
module tb_mux_display;

    localparam int TB_BLINK = 2;

    typedef struct {
        logic [6:0] code;
        logic [5:0] an;
    } digit_vec_t;

    typedef struct {
        int         tag;
        logic [6:0] seg;
        logic [5:0] an;
        logic [2:0] idx;
        logic       tick;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [6:0] s_lsd, s_msd, m_lsd, m_msd, h_lsd, h_msd;
    logic [6:0] seg;
    logic [5:0] an;
    logic [2:0] digit_idx;
    logic       frame_tick;
    logic [5:0] blink_mask;

    digit_vec_t vec [6];
    logic [6:0] exp_code [6];
    logic [5:0] mask_exp;
    exp_t       sb [$];
    int         n;
    int         checks   = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    mux_display #(
        .CLK_HZ       (1000),
        .SCAN_HZ      (100),
        .BLANK_CYCLES (2),
        .BLINK_FRAMES (TB_BLINK)
    ) dut (
        .mux_clock      (clk),
        .mux_reset      (rst_n),
        .mux_enable     (enable),
        .mux_s_lsd      (s_lsd),
        .mux_s_msd      (s_msd),
        .mux_m_lsd      (m_lsd),
        .mux_m_msd      (m_msd),
        .mux_h_lsd      (h_lsd),
        .mux_h_msd      (h_msd),
        .mux_seg        (seg),
        .mux_an         (an),
        .mux_digit_idx  (digit_idx),
        .mux_frame_tick (frame_tick)
`ifdef MUX_BLINK_EN
        ,
        .mux_blink_mask (blink_mask)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Expected outputs k cycles after scan start (cnt=0, idx=0).
    function automatic exp_t model(input int k);
        exp_t e;
        int   slot  = (k / 10) % 6;
        int   c     = k % 10;
        int   frame = k / 60;
        e.tag  = k;
        e.idx  = 3'(slot);
        e.tick = (k > 0) && (k % 60 == 0);
        e.seg  = 7'h7F;
        e.an   = 6'h3F;
        if (c >= 2) begin
            e.seg = exp_code[slot];
            e.an  = vec[slot].an;
            if (((frame / TB_BLINK) % 2 == 1) && mask_exp[slot])
                e.an = 6'h3F;
        end
        return e;
    endfunction

    function automatic exp_t dark();
        exp_t e;
        e.tag  = -1;
        e.seg  = 7'h7F;
        e.an   = 6'h3F;
        e.idx  = 3'd0;
        e.tick = 1'b0;
        return e;
    endfunction

    task automatic check_now(input string name, input exp_t e);
        check(name, {15'd0, seg, an, digit_idx, frame_tick}, {15'd0, e.seg, e.an, e.idx, e.tick});
    endtask

    // Scoreboard consumer: compares queued expectations away from the active edge.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            check_now($sformatf("scan n=%0d", e.tag), e);
        end
    end

    task automatic cycle();
        @(posedge clk);
        n++;
        sb.push_back(model(n));
        @(negedge clk);
    endtask

    task automatic dis_cycle();
        @(posedge clk);
        sb.push_back(dark());
        @(negedge clk);
    endtask

    task automatic drive_codes();
        s_lsd = vec[0].code; s_msd = vec[1].code; m_lsd = vec[2].code;
        m_msd = vec[3].code; h_lsd = vec[4].code; h_msd = vec[5].code;
        for (int i = 0; i < 6; i++) exp_code[i] = vec[i].code;
    endtask

    initial begin
        vec[0] = '{7'h40, 6'h3E};
        vec[1] = '{7'h79, 6'h3D};
        vec[2] = '{7'h24, 6'h3B};
        vec[3] = '{7'h30, 6'h37};
        vec[4] = '{7'h19, 6'h2F};
        vec[5] = '{7'h12, 6'h1F};
        mask_exp   = 6'b000000;
        blink_mask = 6'b000000;
        rst_n  = 1'b0;
        enable = 1'b1;
        drive_codes();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_seg", {25'd0, seg}, 32'h7F);
        check("reset_an", {26'd0, an}, 32'h3F);
        check("reset_idx", {29'd0, digit_idx}, 32'd0);
        check("reset_tick", {31'd0, frame_tick}, 32'd0);

        // Two full frames of scanning
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        check_now("start n=0", model(0));
        repeat (120) cycle();

        // Input change mid-DRIVE of idx 2 is ignored until the next slot
        while (n < 145) cycle();
        m_lsd = 7'h02;
        while (n < 150) cycle();
        exp_code[2] = 7'h02;
        while (n < 215) cycle();

        // Drop enable mid-DRIVE of idx 3, then resume
        enable = 1'b0;
        repeat (4) dis_cycle();
        enable = 1'b1;
        n = 0;
        check_now("resume n=0", model(0));
        repeat (25) cycle();

        // Asynchronous reset mid-DRIVE of idx 2
        #2;
        rst_n = 1'b0;
        #1;
        check_now("async_reset", dark());
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        repeat (15) cycle();

`ifdef MUX_BLINK_EN
        // Blink h_msd with a two-frame half-period
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        blink_mask = 6'b100000;
        mask_exp   = 6'b100000;
        rst_n = 1'b1;
        n = 0;
        repeat (300) cycle();
`endif

        @(negedge clk);
        #1;
        check("queue_drained", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
